fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the pipelined ARM-subset CPU.
//  - Tracks in-flight destination registers itself, in an internal shadow pipeline
//    FWD_STAGES deep (stage 0 = EX, 1 = MEM, 2 = WB, ...).
//  - Generates forwarding mux selects for the Rn, Rm and Rd (Db) operands.
//  - Generates the condition-flag source select for B.cond in ID.
//  - Detects load-use hazards and inserts stall bubbles.
//  - Keeps a saturating stall counter.
// PARAMETERS
//  REG_W      5   register index width; index 2**REG_W-1 (X31/XZR) is never forwarded
//  FWD_STAGES 3   number of downstream stages tracked and forwardable (1..7)
//  LOAD_LAT   1   stages after EX before load data can be forwarded (0..FWD_STAGES-1)
//  CNT_W      16  stall counter width
//  SEL_W      = $clog2(FWD_STAGES+1), derived localparam
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high
//  id_valid     in   1      ID holds a real instruction
//  id_rn        in   REG_W  Rn source index
//  id_rm        in   REG_W  Rm source index
//  id_rd        in   REG_W  destination index; also a source when id_uses_rd=1
//  id_uses_rn   in   1      instruction reads Rn
//  id_uses_rm   in   1      instruction reads Rm
//  id_uses_rd   in   1      instruction reads Rd (STUR data, MOVK)
//  id_reg_write in   1      instruction writes Rd
//  id_is_load   in   1      instruction is LDUR
//  id_set_flag  in   1      instruction sets flags (ADDS/SUBS)
//  id_is_bcond  in   1      instruction is B.cond
//  flush        in   1      kill the instruction in ID (taken branch)
//  fwd_sel_a    out  SEL_W  Rn source: 0 = regfile, k+1 = stage k result
//  fwd_sel_b    out  SEL_W  Rm source, same encoding
//  fwd_sel_d    out  SEL_W  Rd/Db source, same encoding
//  flag_sel     out  SEL_W  flag source: 0 = architectural flags, k+1 = stage k flags
//  stall        out  1      hold PC and IF/ID; the unit inserts a bubble into EX
//  stall_cnt    out  CNT_W  stall cycles since reset, saturating at all-ones
// BEHAVIOUR
//  Entry contents: {v, rd, wr, ld, sf} per tracked stage.
//  On reset (async): all entries v=0; stall_cnt=0.
//    Hence every select = 0 and stall = 0 while reset is high.
//  Each clock edge:
//    - Entry k+1 <= entry k; the last entry is discarded.
//    - Entry 0 <= ID fields with v = id_valid & ~flush & ~stall; otherwise a bubble
//      (v=0, wr=0, sf=0).
//  Select logic (combinational from entries and ID inputs):
//    - Operand match at stage k: v & wr & rd==src & src!=all-ones & uses_src.
//    - sel = 1 + smallest matching k (youngest wins); 0 if no match.
//  flag_sel: 1 + smallest k with v & sf, qualified by id_is_bcond; 0 otherwise.
//  Load-use stall:
//    - stall = id_valid & ~flush & (some used operand matches a stage k with
//      ld=1 and k < LOAD_LAT).
//    - Selects remain computed during a stall; downstream muxes ignore them for the bubble.
//    - Stall lasts exactly LOAD_LAT - k cycles for youngest-match stage k; deasserts
//      with no extra cycle.
//  Simultaneous events:
//    - flush with a hazard: flush wins; stall = 0 and the ID instruction becomes a bubble.
//  stall_cnt: increments on each edge with stall=1; holds at 2**CNT_W-1.
//  Reset mid-stall: stall drops immediately (async); the in-flight instruction is
//    forgotten, with no forwarding afterwards.
//  Latency:
//    - Selects and stall: 0 cycles from ID inputs.
//    - Tracking update: 1 cycle.
//  FWD_STAGES=2, LOAD_LAT=1 with id_is_bcond: equals the original EX-only
//    direct-flag behaviour plus MEM.
// TESTING (FWD_STAGES=3, LOAD_LAT=1 unless noted)
//  1. ADD X1; then SUB uses Rn=X1 -> fwd_sel_a=1. Next cycle (X1 in MEM), an unrelated
//     instruction reading X1 -> fwd_sel_a=2. Then WB -> 3. Then 0.
//  2. ADD X2 followed by ADD X2, then ID reads Rm=X2 -> fwd_sel_b=1 (youngest wins, not 2).
//     With X31 as both destination and source -> fwd_sel_b=0.
//  3. LDUR X3, then ADD reading X3 -> stall=1 for 1 cycle, fwd_sel_a=2 the next cycle,
//     stall_cnt=1. Repeat with LOAD_LAT=2 -> 2 stall cycles, then fwd_sel_a=3.
//  4. SUBS, then B.cond -> flag_sel=1. With one NOP between -> flag_sel=2.
//     With no setter in the 3 tracked stages -> flag_sel=0.
//  5. LDUR X4, then STUR with Rd=X4 and flush=1 in the same cycle -> stall=0; the
//     entry becomes a bubble and no selects point at it afterwards.
//  6. Assert reset during a LOAD_LAT=2 stall -> stall=0 and stall_cnt=0 immediately.
//     With CNT_W=2, force 5 stall cycles -> stall_cnt holds 3.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows in-flight destinations,
// picks the youngest producer for each operand and the flag source, and stalls on load-use.
module fwd_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             id_uses_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             id_set_flag,
    input  logic             id_is_bcond,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [SEL_W-1:0] fwd_sel_d,
    output logic [SEL_W-1:0] flag_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] XZR = '1;

    // Shadow pipeline, index k = stage k downstream of ID (0 = EX)
    logic             ent_v_p  [FWD_STAGES];
    logic             ent_wr_p [FWD_STAGES];
    logic             ent_ld_p [FWD_STAGES];
    logic             ent_sf_p [FWD_STAGES];
    logic [REG_W-1:0] ent_rd_p [FWD_STAGES];

    logic issue;
    logic hazard;

    function automatic logic op_match(input logic v, input logic wr,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] src,
                                      input logic uses);
        return v & wr & uses & (rd == src) & (src != XZR);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != '1))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    // ID stage: selects and hazard, combinational from ID fields and entries
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        fwd_sel_d = '0;
        flag_sel  = '0;
        hazard    = 1'b0;
        // Walk oldest to youngest so the youngest match is written last
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (op_match(ent_v_p[k], ent_wr_p[k], ent_rd_p[k], id_rn, id_uses_rn)) begin
                fwd_sel_a = SEL_W'(k + 1);
                if (ent_ld_p[k] && (k < LOAD_LAT)) hazard = 1'b1;
            end
            if (op_match(ent_v_p[k], ent_wr_p[k], ent_rd_p[k], id_rm, id_uses_rm)) begin
                fwd_sel_b = SEL_W'(k + 1);
                if (ent_ld_p[k] && (k < LOAD_LAT)) hazard = 1'b1;
            end
            if (op_match(ent_v_p[k], ent_wr_p[k], ent_rd_p[k], id_rd, id_uses_rd)) begin
                fwd_sel_d = SEL_W'(k + 1);
                if (ent_ld_p[k] && (k < LOAD_LAT)) hazard = 1'b1;
            end
            if (ent_v_p[k] && ent_sf_p[k] && id_is_bcond)
                flag_sel = SEL_W'(k + 1);
        end
    end

    // Flush beats a hazard; a stalled instruction stays in ID and EX gets a bubble
    assign stall = id_valid & ~flush & hazard;
    assign issue = id_valid & ~flush & ~stall;

    // ID -> EX and downstream: control bits, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                ent_v_p[k]  <= 1'b0;
                ent_wr_p[k] <= 1'b0;
                ent_ld_p[k] <= 1'b0;
                ent_sf_p[k] <= 1'b0;
            end
            stall_cnt <= '0;
        end else begin
            ent_v_p[0]  <= issue;
            ent_wr_p[0] <= issue & id_reg_write;
            ent_ld_p[0] <= issue & id_is_load;
            ent_sf_p[0] <= issue & id_set_flag;
            for (int k = 1; k < FWD_STAGES; k++) begin
                ent_v_p[k]  <= ent_v_p[k-1];
                ent_wr_p[k] <= ent_wr_p[k-1];
                ent_ld_p[k] <= ent_ld_p[k-1];
                ent_sf_p[k] <= ent_sf_p[k-1];
            end
            stall_cnt <= sat_inc(stall_cnt, stall);
        end
    end

    // Register indices are only meaningful when the valid bit is set
    always_ff @(posedge clk) begin
        ent_rd_p[0] <= id_rd;
        for (int k = 1; k < FWD_STAGES; k++)
            ent_rd_p[k] <= ent_rd_p[k-1];
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=2,
// LOAD_LAT=2 with a 2-bit counter) share the ID stimulus.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rn, id_uses_rm, id_uses_rd;
    logic       id_reg_write, id_is_load, id_set_flag, id_is_bcond, flush;
    logic [4:0] id_rn, id_rm, id_rd;

    logic [1:0]  a1, b1, d1, f1, a2, b2, d2, f2, a3, b3, d3, f3;
    logic        s1, s2, s3;
    logic [15:0] c1, c2;
    logic [1:0]  c3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_W(5), .FWD_STAGES(3), .LOAD_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rd(id_rd), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_uses_rd(id_uses_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_set_flag(id_set_flag), .id_is_bcond(id_is_bcond), .flush(flush),
        .fwd_sel_a(a1), .fwd_sel_b(b1), .fwd_sel_d(d1), .flag_sel(f1),
        .stall(s1), .stall_cnt(c1));

    fwd_hazard_ctrl #(.REG_W(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rd(id_rd), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_uses_rd(id_uses_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_set_flag(id_set_flag), .id_is_bcond(id_is_bcond), .flush(flush),
        .fwd_sel_a(a2), .fwd_sel_b(b2), .fwd_sel_d(d2), .flag_sel(f2),
        .stall(s2), .stall_cnt(c2));

    fwd_hazard_ctrl #(.REG_W(5), .FWD_STAGES(3), .LOAD_LAT(2), .CNT_W(2)) u3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_rd(id_rd), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_uses_rd(id_uses_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_set_flag(id_set_flag), .id_is_bcond(id_is_bcond), .flush(flush),
        .fwd_sel_a(a3), .fwd_sel_b(b3), .fwd_sel_d(d3), .flag_sel(f3),
        .stall(s3), .stall_cnt(c3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // valid, rn, rm, rd, uses rn/rm/rd, reg_write, load, set_flag, bcond, flush
    task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic un, input logic um,
                          input logic ud, input logic wr, input logic ld,
                          input logic sf, input logic bc, input logic fl);
        id_valid = v;  id_rn = rn; id_rm = rm; id_rd = rd;
        id_uses_rn = un; id_uses_rm = um; id_uses_rd = ud;
        id_reg_write = wr; id_is_load = ld; id_set_flag = sf;
        id_is_bcond = bc; flush = fl;
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        nop();
        tick();
        tick();
        // Reset state
        chk("rst_sel_a", 32'(a1), 0);
        chk("rst_stall", 32'(s1), 0);
        chk("rst_cnt", 32'(c1), 0);
        reset = 1'b0;

        // Forwarding from EX, MEM, WB, then gone
        set_id(1, 5, 6, 1, 1, 1, 0, 1, 0, 0, 0, 0);          // ADD X1
        tick();
        set_id(1, 1, 0, 7, 1, 0, 0, 1, 0, 0, 0, 0);          // SUB X7, X1
        chk("t1_ex", 32'(a1), 1);
        tick();
        set_id(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);          // reader of X1
        chk("t1_mem", 32'(a1), 2);
        tick();
        chk("t1_wb", 32'(a1), 3);
        tick();
        chk("t1_gone", 32'(a1), 0);
        nop(); tick(); tick(); tick();

        // Youngest producer wins; X31 never forwarded
        set_id(1, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0);          // ADD X2
        tick();
        tick();                                              // ADD X2 again
        set_id(1, 2, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);          // reads Rm=X2 only
        chk("t2_youngest", 32'(b1), 1);
        chk("t2_unused_rn", 32'(a1), 0);
        tick();
        set_id(1, 0, 0, 31, 0, 0, 0, 1, 0, 0, 0, 0);         // ADD X31
        tick();
        set_id(1, 2, 31, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("t2_xzr", 32'(b1), 0);
        chk("t2_old_x2", 32'(a1), 3);
        nop(); tick(); tick(); tick();

        // Load-use, LOAD_LAT=1
        set_id(1, 9, 0, 3, 1, 0, 0, 1, 1, 0, 0, 0);          // LDUR X3
        tick();
        set_id(1, 3, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0);         // ADD X10, X3
        chk("t3_stall", 32'(s1), 1);
        chk("t3_sel_in_stall", 32'(a1), 1);
        tick();
        chk("t3_stall_end", 32'(s1), 0);
        chk("t3_sel_mem", 32'(a1), 2);
        chk("t3_cnt", 32'(c1), 1);
        tick();
        nop();
        chk("t3_cnt_hold", 32'(c1), 1);
        tick(); tick(); tick();

        // Flag source for B.cond
        set_id(1, 0, 0, 11, 0, 0, 0, 1, 0, 1, 0, 0);         // SUBS
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_no_bcond", 32'(f1), 0);
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);          // B.cond
        chk("t4_ex", 32'(f1), 1);
        nop();
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t4_mem", 32'(f1), 2);
        tick();
        chk("t4_wb", 32'(f1), 3);
        tick();
        chk("t4_none", 32'(f1), 0);
        nop(); tick(); tick(); tick();

        // Flush beats hazard; flushed instruction becomes a bubble
        set_id(1, 0, 0, 4, 0, 0, 0, 1, 1, 0, 0, 0);          // LDUR X4
        tick();
        set_id(1, 12, 0, 4, 1, 0, 1, 0, 0, 0, 0, 1);         // STUR X4 + flush
        chk("t5_flush_stall", 32'(s1), 0);
        tick();
        set_id(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("t5_sel_d", 32'(d1), 2);
        chk("t5_nostall", 32'(s1), 0);
        chk("t5_cnt", 32'(c1), 1);
        set_id(1, 0, 0, 13, 0, 0, 0, 1, 0, 0, 0, 1);         // ADD X13 + flush
        tick();
        set_id(1, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_bubble", 32'(a1), 0);

        // LOAD_LAT=2 instances from a clean reset
        reset = 1'b1;
        nop();
        tick();
        chk("t6_rst_cnt2", 32'(c2), 0);
        reset = 1'b0;
        set_id(1, 9, 0, 3, 1, 0, 0, 1, 1, 0, 0, 0);          // LDUR X3
        tick();
        set_id(1, 3, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0);         // ADD X10, X3
        chk("t6_stall1", 32'(s2), 1);
        chk("t6_sel1", 32'(a2), 1);
        tick();
        chk("t6_stall2", 32'(s2), 1);
        chk("t6_sel2", 32'(a2), 2);
        chk("t6_cnt1", 32'(c2), 1);
        tick();
        chk("t6_stall_end", 32'(s2), 0);
        chk("t6_sel3", 32'(a2), 3);
        chk("t6_cnt2", 32'(c2), 2);
        chk("t6_cnt2_narrow", 32'(c3), 2);
        tick();
        nop();

        // Second load-use pair: 4 stall edges, 2-bit counter saturates
        set_id(1, 9, 0, 3, 1, 0, 0, 1, 1, 0, 0, 0);
        tick();
        set_id(1, 3, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0);
        chk("t6_pair2_stall", 32'(s3), 1);
        tick();
        tick();
        chk("t6_sat_4", 32'(c3), 3);
        chk("t6_wide_4", 32'(c2), 4);
        tick();
        nop();

        // Third pair: one more stall edge (5 total), then reset mid-stall
        set_id(1, 9, 0, 3, 1, 0, 0, 1, 1, 0, 0, 0);
        tick();
        set_id(1, 3, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        chk("t6_sat_5", 32'(c3), 3);
        chk("t6_wide_5", 32'(c2), 5);
        chk("t6_mid_stall", 32'(s3), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_stall", 32'(s3), 0);
        chk("t6_rst_cnt", 32'(c3), 0);
        chk("t6_rst_sel", 32'(a3), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_forgotten_sel", 32'(a2), 0);
        chk("t6_forgotten_stall", 32'(s2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
